// File: rtl/qu_common.sv
// rtl/qu_common.sv - shared reservation station constants, index type and cell type
package qu_common;

    localparam int RS_ENTRIES    = 4;
    localparam int RS_TAG_WIDTH  = 5;
    localparam int RS_DATA_WIDTH = 32;
    localparam int RS_OP_WIDTH   = 6;

    typedef logic [$clog2(RS_ENTRIES)-1:0] rs_idx_t;

    typedef struct packed {
        logic                     busy;
        logic [RS_OP_WIDTH-1:0]   op;
        logic [RS_TAG_WIDTH-1:0]  qj;
        logic [RS_TAG_WIDTH-1:0]  qk;
        logic [RS_DATA_WIDTH-1:0] vj;
        logic [RS_DATA_WIDTH-1:0] vk;
        logic [RS_DATA_WIDTH-1:0] a;
    } res_st_cell_t;

    // Tag 0 means "operand already present", so it never matches a broadcast.
    function automatic logic cdb_match(input logic                    cdb_valid,
                                       input logic [RS_TAG_WIDTH-1:0] cdb_tag,
                                       input logic [RS_TAG_WIDTH-1:0] q);
        return cdb_valid && (cdb_tag != '0) && (cdb_tag == q);
    endfunction

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - lowest-index priority encoder returning found flag and index
module rs_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station with CDB capture and registered issue
module reservation_station
    import qu_common::*;
#(
    parameter int ENTRIES    = RS_ENTRIES,
    parameter int TAG_WIDTH  = RS_TAG_WIDTH,
    parameter int DATA_WIDTH = RS_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_in,
    input  logic                       dispatch_valid_in,
    input  res_st_cell_t               dispatch_cell_in,
    output logic                       dispatch_ready_out,
    input  logic                       cdb_valid_in,
    input  logic [TAG_WIDTH-1:0]       cdb_tag_in,
    input  logic [DATA_WIDTH-1:0]      cdb_value_in,
    output logic                       issue_valid_out,
    output res_st_cell_t               issue_cell_out,
    input  logic                       issue_ready_in,
    output logic [$clog2(ENTRIES+1)-1:0] count_out
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    res_st_cell_t      slots [ENTRIES];
    res_st_cell_t      woken [ENTRIES];
    res_st_cell_t      disp_cell;
    logic [ENTRIES-1:0] busy_vec;
    logic [ENTRIES-1:0] free_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic              free_found;
    logic              ready_found;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  ready_idx;
    logic              accept;
    logic              load;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            busy_vec[i]  = slots[i].busy;
            ready_vec[i] = slots[i].busy && (slots[i].qj == '0) && (slots[i].qk == '0);
        end
    end

    assign free_vec = ~busy_vec;

    rs_select #(.N(ENTRIES), .IDX_W(IDX_W)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.N(ENTRIES), .IDX_W(IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    assign dispatch_ready_out = free_found;
    assign accept             = dispatch_valid_in && dispatch_ready_out;
    assign load               = (!issue_valid_out || issue_ready_in) && ready_found;

    // An operand produced in the same cycle it is dispatched is captured here,
    // otherwise it would miss its only broadcast.
    always_comb begin
        disp_cell      = dispatch_cell_in;
        disp_cell.busy = 1'b1;
        if (cdb_match(cdb_valid_in, cdb_tag_in, dispatch_cell_in.qj)) begin
            disp_cell.vj = cdb_value_in;
            disp_cell.qj = '0;
        end
        if (cdb_match(cdb_valid_in, cdb_tag_in, dispatch_cell_in.qk)) begin
            disp_cell.vk = cdb_value_in;
            disp_cell.qk = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            woken[i] = slots[i];
            if (slots[i].busy && cdb_match(cdb_valid_in, cdb_tag_in, slots[i].qj)) begin
                woken[i].vj = cdb_value_in;
                woken[i].qj = '0;
            end
            if (slots[i].busy && cdb_match(cdb_valid_in, cdb_tag_in, slots[i].qk)) begin
                woken[i].vk = cdb_value_in;
                woken[i].qk = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= '0;
            end
            issue_valid_out <= 1'b0;
            issue_cell_out  <= '0;
            count_out       <= '0;
        end else begin
            // The issued slot is busy and the dispatch slot is free, so they never collide.
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= woken[i];
                if (load && (ready_idx == IDX_W'(i))) begin
                    slots[i].busy <= 1'b0;
                end
                if (accept && (free_idx == IDX_W'(i))) begin
                    slots[i] <= disp_cell;
                end
            end

            if (load) begin
                issue_cell_out      <= slots[ready_idx];
                issue_cell_out.qj   <= '0;
                issue_cell_out.qk   <= '0;
                issue_cell_out.busy <= 1'b1;
                issue_valid_out     <= 1'b1;
            end else if (issue_ready_in && issue_valid_out) begin
                issue_valid_out <= 1'b0;
            end

            count_out <= count_out + CNT_W'(accept) - CNT_W'(load);
        end
    end

endmodule
